// File: rtl/toggle_pkg.sv
// Shared definitions for the single-wire toggle link (transmitter and receiver).
// State encoding is fixed so both ends agree on the WAKE/IDLE/PULSE/GAP numbering.
package toggle_pkg;

  typedef enum logic [1:0] {
    ST_WAKE  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } toggle_state_t;

  localparam int GAP_MIN = 1;
  localparam int GAP_MAX = 255;

  // Out-of-range GAP values are clamped so the 8-bit gap timer can never wrap.
  function automatic logic [7:0] gap_reload(input int gap);
    int g;
    g = gap;
    if (g < GAP_MIN) g = GAP_MIN;
    if (g > GAP_MAX) g = GAP_MAX;
    return 8'(g - 1);
  endfunction

endpackage

// File: rtl/toggle_gap_timer.sv
// 8-bit loadable down-counter that times the low cycles between pulses.
// The count stops at zero; the zero flag comes straight from the register.
module toggle_gap_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 8'd0;
    end else if (load) begin
      count_reg <= value;
    end else if (dec && (count_reg != 8'd0)) begin
      count_reg <= count_reg - 8'd1;
    end
  end

  assign zero = (count_reg == 8'd0);

endmodule

// File: rtl/toggle_pulse_tx.sv
// Transmit side of the toggle link: turns a request for N toggles into N spaced pulses.
// Optional build macro TOGGLE_TX_CNT_EN adds the 16-bit saturating pulse_total counter.
module toggle_pulse_tx
  import toggle_pkg::*;
#(
  parameter int CW  = 4,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [CW-1:0] req_count,
  output logic          req_ready,
  input  logic          abort,
  output logic          din_o,
  output logic          busy,
  output logic          level_o
`ifdef TOGGLE_TX_CNT_EN
  ,
  output logic [15:0]   pulse_total
`endif
);

  localparam logic [7:0] GAP_RELOAD = gap_reload(GAP);

  toggle_state_t state_reg, state_next;
  logic [CW-1:0] remaining_reg, remaining_next;
  logic          level_reg, level_next;
  logic          din_reg, ready_reg, busy_reg;
  logic          gap_load, gap_dec, gap_zero;
  logic          pulse_end;

  toggle_gap_timer u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (gap_load),
    .value (GAP_RELOAD),
    .dec   (gap_dec),
    .zero  (gap_zero)
  );

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    gap_load       = 1'b0;
    gap_dec        = 1'b0;
    pulse_end      = 1'b0;
    unique case (state_reg)
      ST_WAKE: begin
        state_next = ST_IDLE;
      end
      ST_IDLE: begin
        // A zero-length request is consumed here without leaving IDLE.
        if (req_valid && (req_count != '0)) begin
          remaining_next = req_count;
          state_next     = ST_PULSE;
        end
      end
      ST_PULSE: begin
        // The pulse is already on the wire, so it counts even when aborted.
        pulse_end = 1'b1;
        if (abort) begin
          remaining_next = '0;
          state_next     = ST_IDLE;
        end else begin
          remaining_next = remaining_reg - CW'(1);
          gap_load       = 1'b1;
          state_next     = ST_GAP;
        end
      end
      ST_GAP: begin
        if (abort) begin
          remaining_next = '0;
          state_next     = ST_IDLE;
        end else if (!gap_zero) begin
          gap_dec = 1'b1;
        end else if (remaining_reg != '0) begin
          state_next = ST_PULSE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_WAKE;
      end
    endcase
  end

  assign level_next = level_reg ^ pulse_end;

  // Outputs are registered from the next state so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_WAKE;
      remaining_reg <= '0;
      level_reg     <= 1'b0;
      din_reg       <= 1'b0;
      ready_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      level_reg     <= level_next;
      din_reg       <= (state_next == ST_PULSE);
      ready_reg     <= (state_next == ST_IDLE);
      busy_reg      <= (state_next == ST_PULSE) || (state_next == ST_GAP);
    end
  end

  assign din_o     = din_reg;
  assign req_ready = ready_reg;
  assign busy      = busy_reg;
  assign level_o   = level_reg;

`ifdef TOGGLE_TX_CNT_EN
  logic [15:0] total_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_reg <= 16'd0;
    end else if (pulse_end && (total_reg != 16'hFFFF)) begin
      total_reg <= total_reg + 16'd1;
    end
  end

  assign pulse_total = total_reg;
`endif

endmodule
